// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte producers,
// with a start/done handshake and a tick-counted idle gap after every frame.
// Optional build macro UART_ARB_FIXED_PRIO_EN: lowest valid index always wins.
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int NB_DATA   = 8,
  parameter int GAP_TICKS = 16,
  parameter int NB_ID     = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic                     i_tick,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [N_REQ*NB_DATA-1:0] i_req_data,
  output logic [N_REQ-1:0]         o_req_ready,
  output logic                     o_tx_start,
  output logic [NB_DATA-1:0]       o_tx_data,
  input  logic                     i_tx_done,
  output logic [NB_ID-1:0]         o_grant_id,
  output logic                     o_busy
);

  // A zero gap never enters GAP, but the counter still needs a legal width.
  localparam int NB_GAP = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [NB_GAP-1:0] GAP_LAST = NB_GAP'(GAP_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_tx_start;
  logic [NB_DATA-1:0]   r_tx_data;
  logic [NB_ID-1:0]     r_grant_id;
  logic                 r_busy;
  logic [NB_GAP-1:0]    r_gap_cnt;
`ifndef UART_ARB_FIXED_PRIO_EN
  logic [NB_ID-1:0]     r_ptr;
`endif

  logic [NB_DATA-1:0]   w_req_data [N_REQ];
  logic                 w_win_found;
  logic [NB_ID-1:0]     w_win_id;
  logic [NB_ID-1:0]     w_idx;
  logic [NB_GAP-1:0]    w_gap_inc;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_req_data[gi] = i_req_data[gi*NB_DATA +: NB_DATA];
    end
  endgenerate

`ifdef UART_ARB_FIXED_PRIO_EN
  // Scan from the top so the lowest valid index is the last one written.
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = '0;
    w_idx       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = NB_ID'(k);
      if (i_req_valid[w_idx]) begin
        w_win_found = 1'b1;
        w_win_id    = w_idx;
      end
    end
  end
`else
  // First valid index strictly after the last winner, wrapping around.
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = '0;
    w_idx       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = NB_ID'((int'(r_ptr) + k) % N_REQ);
      if (!w_win_found && i_req_valid[w_idx]) begin
        w_win_found = 1'b1;
        w_win_id    = w_idx;
      end
    end
  end
`endif

  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign o_req_ready[gi] = i_rst_n && (r_state == ST_IDLE) && w_win_found &&
                               (w_win_id == NB_ID'(gi));
    end
  endgenerate

  assign w_gap_inc = r_gap_cnt + 1'b1;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_grant_id <= '0;
      r_busy     <= 1'b0;
      r_gap_cnt  <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
      r_ptr      <= NB_ID'(N_REQ - 1);
`endif
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_win_found) begin
            r_tx_data  <= w_req_data[w_win_id];
            r_grant_id <= w_win_id;
`ifndef UART_ARB_FIXED_PRIO_EN
            r_ptr      <= w_win_id;
`endif
            r_tx_start <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          r_state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (i_tx_done) begin
            if (GAP_TICKS == 0) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_gap_cnt <= '0;
              r_state   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (i_tick) begin
            r_gap_cnt <= w_gap_inc;
            if (w_gap_inc == GAP_LAST) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;
  assign o_grant_id = r_grant_id;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a no-gap and a 16-tick-gap instance on shared inputs,
// directed vectors/sequences plus random stimulus against a frame-level model.
module tb_uart_tx_arbiter;

`ifdef UART_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        done = 1'b0;
  logic [3:0]  valid = 4'b0000;
  logic [31:0] data = 32'h3CA52211;

  logic [3:0] rdy0, rdy1;
  logic       st0, st1, busy0, busy1;
  logic [7:0] txd0, txd1;
  logic [1:0] gid0, gid1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(4), .NB_DATA(8), .GAP_TICKS(0)) u_dut0 (
    .clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_req_valid(valid), .i_req_data(data),
    .o_req_ready(rdy0), .o_tx_start(st0), .o_tx_data(txd0), .i_tx_done(done),
    .o_grant_id(gid0), .o_busy(busy0)
  );

  uart_tx_arbiter #(.N_REQ(4), .NB_DATA(8), .GAP_TICKS(16)) u_dut1 (
    .clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_req_valid(valid), .i_req_data(data),
    .o_req_ready(rdy1), .o_tx_start(st1), .o_tx_data(txd1), .i_tx_done(done),
    .o_grant_id(gid1), .o_busy(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = 4'b0000;
    done  = 1'b0;
    tick  = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_ready0", 32'(rdy0), 0);
    chk("rst_start0", 32'(st0), 0);
    chk("rst_busy0", 32'(busy0), 0);
    chk("rst_data0", 32'(txd0), 0);
    chk("rst_gid0", 32'(gid0), 0);
    chk("rst_busy1", 32'(busy1), 0);
    chk("rst_start1", 32'(st1), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Frame-level reference: winner search over requester indices.
  function automatic int mdl_winner(input logic [3:0] v, input int p);
    int idx;
    if (FIXED) begin
      for (int k = 0; k < 4; k++) begin
        idx = k;
        if (v[idx[1:0]]) return k;
      end
    end else begin
      for (int s = 1; s <= 4; s++) begin
        idx = (p + s) % 4;
        if (v[idx[1:0]]) return idx;
      end
    end
    return -1;
  endfunction

  typedef struct packed {
    logic [3:0] valid;
    logic       done;
    logic       tick;
    logic [3:0] ready;
    logic       start;
    logic       busy;
    logic [1:0] gid;
    logic [7:0] txd;
  } vec_t;

  localparam logic [3:0] C4R  = FIXED ? 4'b0001 : 4'b1000;
  localparam logic [1:0] C5G  = FIXED ? 2'd0 : 2'd3;
  localparam logic [7:0] C5D  = FIXED ? 8'h11 : 8'h3C;
  localparam logic [3:0] C13R = FIXED ? 4'b0001 : 4'b0100;

  // Model state, index 0 = no-gap instance, 1 = 16-tick-gap instance.
  int         m_phase [2];   // 0 idle, 1 start, 2 waiting for done, 3 gap
  int         m_left  [2];
  int         m_ptr   [2];
  logic [7:0] m_data  [2];
  logic [1:0] m_gid   [2];

  initial begin
    vec_t tbl [14];
    int   found, lat, w, exp_id, fall, nt, viol;
    logic [3:0] acc;

    tbl[0]  = '{4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 8'h00};
    tbl[1]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 8'hA5};
    tbl[2]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 8'hA5};
    tbl[3]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 8'hA5};
    tbl[4]  = '{4'b1001, 1'b0, 1'b0, C4R,     1'b0, 1'b0, 2'd2, 8'hA5};
    tbl[5]  = '{4'b0110, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, C5G,  C5D};
    tbl[6]  = '{4'b0110, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, C5G,  C5D};
    tbl[7]  = '{4'b0110, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, C5G,  C5D};
    tbl[8]  = '{4'b0110, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, C5G,  C5D};
    tbl[9]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 8'h22};
    tbl[10] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 8'h22};
    tbl[11] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 8'h22};
    tbl[12] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1, 8'h22};
    tbl[13] = '{4'b0101, 1'b0, 1'b0, C13R,    1'b0, 1'b0, 2'd1, 8'h22};

    // Vector table on the no-gap instance, one row per cycle.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      valid = tbl[i].valid;
      done  = tbl[i].done;
      tick  = tbl[i].tick;
      #1;
      $display("vec %0d: valid=%b ready=%b start=%b busy=%b gid=%0d data=%h",
               i, valid, rdy0, st0, busy0, gid0, txd0);
      chk($sformatf("vec%0d_ready", i), 32'(rdy0), 32'(tbl[i].ready));
      chk($sformatf("vec%0d_start", i), 32'(st0), 32'(tbl[i].start));
      chk($sformatf("vec%0d_busy", i), 32'(busy0), 32'(tbl[i].busy));
      chk($sformatf("vec%0d_gid", i), 32'(gid0), 32'(tbl[i].gid));
      chk($sformatf("vec%0d_data", i), 32'(txd0), 32'(tbl[i].txd));
      @(negedge clk);
    end

    // Fairness: all valid, done 10 cycles after each start, no gap.
    do_reset();
    valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_id = FIXED ? 0 : (g % 4);
      found = 0;
      lat = 0;
      for (int t = 0; t < 50; t++) begin
        #1;
        if (rdy0 != 4'b0000) begin
          found = 1;
          lat = t;
          break;
        end
        @(negedge clk);
      end
      chk("rr_found", 32'(found), 1);
      if (found == 0) break;
      w = mdl_winner(rdy0, 3);
      $display("grant %0d: ready=%b id=%0d", g, rdy0, w);
      chk("rr_order", 32'(w), 32'(exp_id));
      if (g > 0) chk("rr_latency", 32'(lat), 0);
      acc = rdy0;
      @(negedge clk);
      valid = valid & ~acc;
      #1;
      chk("rr_start", 32'(st0), 1);
      chk("rr_gid", 32'(gid0), 32'(exp_id));
      @(negedge clk);
      valid = valid | acc;
      repeat (9) @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
    end

    // Gap: tick every 4 cycles, one in the done cycle, spurious dones in START and GAP.
    do_reset();
    fall = -1;
    nt = 0;
    viol = 0;
    for (int c = 0; c < 200; c++) begin
      tick  = (c % 4 == 0);
      done  = (c == 1 || c == 8 || c == 20);
      valid = (c == 0) ? 4'b0001 : ((c > 8) ? 4'b1111 : 4'b0000);
      #1;
      if (c == 1) chk("gap_start", 32'(st1), 1);
      if (c > 8) begin
        if (!busy1) begin
          fall = c;
          chk("gap_ready_after", 32'(rdy1), FIXED ? 32'h1 : 32'h2);
          break;
        end
        if (rdy1 != 4'b0000) viol++;
        if (tick) nt++;
      end
      @(negedge clk);
    end
    tick = 1'b0;
    done = 1'b0;
    $display("gap: busy fell at cycle %0d after %0d ticks", fall, nt);
    chk("gap_fall_cycle", 32'(fall), 73);
    chk("gap_ticks", 32'(nt), 16);
    chk("gap_no_ready", 32'(viol), 0);

    // Reset while waiting for done.
    do_reset();
    valid = 4'b0001;
    @(negedge clk);
    valid = 4'b0000;
    @(negedge clk);
    #2;
    chk("mid_busy_before", 32'(busy0), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy0", 32'(busy0), 0);
    chk("mid_busy1", 32'(busy1), 0);
    chk("mid_start0", 32'(st0), 0);
    chk("mid_data0", 32'(txd0), 0);
    chk("mid_gid0", 32'(gid0), 0);
    chk("mid_ready0", 32'(rdy0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    valid = 4'b1111;
    #1;
    chk("mid_first_grant0", 32'(rdy0), 1);
    chk("mid_first_grant1", 32'(rdy1), 1);

    // Random stimulus against the model, both instances.
    do_reset();
    for (int m = 0; m < 2; m++) begin
      m_phase[m] = 0;
      m_left[m]  = 0;
      m_ptr[m]   = 3;
      m_data[m]  = 8'h00;
      m_gid[m]   = 2'd0;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      #1;
      chk("rnd_start0", 32'(st0), 32'(m_phase[0] == 1));
      chk("rnd_busy0", 32'(busy0), 32'(m_phase[0] != 0));
      chk("rnd_gid0", 32'(gid0), 32'(m_gid[0]));
      chk("rnd_data0", 32'(txd0), 32'(m_data[0]));
      chk("rnd_start1", 32'(st1), 32'(m_phase[1] == 1));
      chk("rnd_busy1", 32'(busy1), 32'(m_phase[1] != 0));
      chk("rnd_gid1", 32'(gid1), 32'(m_gid[1]));
      chk("rnd_data1", 32'(txd1), 32'(m_data[1]));
      valid = 4'($urandom);
      data  = $urandom;
      tick  = ($urandom_range(0, 2) == 0);
      done  = ($urandom_range(0, 5) == 0);
      #1;
      for (int m = 0; m < 2; m++) begin
        logic [3:0] exp_rdy;
        exp_rdy = 4'b0000;
        if (m_phase[m] == 0 && valid != 4'b0000)
          exp_rdy = 4'b0001 << mdl_winner(valid, m_ptr[m]);
        chk($sformatf("rnd_ready%0d", m), 32'((m == 0) ? rdy0 : rdy1), 32'(exp_rdy));
        case (m_phase[m])
          0: if (valid != 4'b0000) begin
               w = mdl_winner(valid, m_ptr[m]);
               m_data[m]  = data[w*8 +: 8];
               m_gid[m]   = w[1:0];
               m_ptr[m]   = w;
               m_phase[m] = 1;
             end
          1: m_phase[m] = 2;
          2: if (done) begin
               if (m == 0) m_phase[m] = 0;
               else begin
                 m_left[m]  = 16;
                 m_phase[m] = 3;
               end
             end
          default: if (tick) begin
               m_left[m] = m_left[m] - 1;
               if (m_left[m] == 0) m_phase[m] = 0;
             end
        endcase
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
